// File: rtl/decade_counter_4017_pkg.sv
// Shared constants for the 74HC4017 Johnson decade counter: state width and
// the ten legal Johnson encodings, plus a legality helper.
package decade_counter_4017_pkg;

  localparam int unsigned J4017_W = 5;

  typedef enum logic [J4017_W-1:0] {
    J4017_C0 = 5'b00000,
    J4017_C1 = 5'b00001,
    J4017_C2 = 5'b00011,
    J4017_C3 = 5'b00111,
    J4017_C4 = 5'b01111,
    J4017_C5 = 5'b11111,
    J4017_C6 = 5'b11110,
    J4017_C7 = 5'b11100,
    J4017_C8 = 5'b11000,
    J4017_C9 = 5'b10000
  } j4017_e;

  function automatic logic j4017_legal(input logic [J4017_W-1:0] js);
    logic ok;
    ok = 1'b0;
    case (js)
      J4017_C0, J4017_C1, J4017_C2, J4017_C3, J4017_C4,
      J4017_C5, J4017_C6, J4017_C7, J4017_C8, J4017_C9: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [J4017_W-1:0] j4017_step(input logic [J4017_W-1:0] js);
    return {js[J4017_W-2:0], ~js[J4017_W-1]};
  endfunction

endpackage

// File: rtl/decade_counter_4017_johnson10_decode.sv
// Johnson-state to 1-of-10 decoder with divide-by-10 carry; illegal states
// decode to all-zero Q outputs.
module johnson10_decode
  import decade_counter_4017_pkg::*;
(
  input  logic [J4017_W-1:0] js_i,
  output logic [9:0]         q_o,
  output logic               carry_o
);

  always_comb begin
    q_o = '0;
    case (js_i)
      J4017_C0: q_o[0] = 1'b1;
      J4017_C1: q_o[1] = 1'b1;
      J4017_C2: q_o[2] = 1'b1;
      J4017_C3: q_o[3] = 1'b1;
      J4017_C4: q_o[4] = 1'b1;
      J4017_C5: q_o[5] = 1'b1;
      J4017_C6: q_o[6] = 1'b1;
      J4017_C7: q_o[7] = 1'b1;
      J4017_C8: q_o[8] = 1'b1;
      J4017_C9: q_o[9] = 1'b1;
      default:  q_o = '0;
    endcase
  end

  assign carry_o = ~js_i[J4017_W-1];

endmodule

// File: rtl/decade_counter_4017.sv
// Pin-level 74HC4017 Johnson decade counter. Define STRUCT74_4017_SELFCORRECT_EN
// to force any illegal Johnson state back to count 0 on the next clock.
module decade_counter_4017
  import decade_counter_4017_pkg::*;
(
  input  logic pin14,
  input  logic pin15,
  input  logic pin13,
  input  logic pin8,
  input  logic pin16,
  output logic pin3,
  output logic pin2,
  output logic pin4,
  output logic pin7,
  output logic pin10,
  output logic pin1,
  output logic pin5,
  output logic pin6,
  output logic pin9,
  output logic pin11,
  output logic pin12
);

  logic [J4017_W-1:0] js_q;
  logic [J4017_W-1:0] js_d;
  logic [9:0]         q;
  logic               carry;
  logic               supply_unused;

  assign supply_unused = pin8 ^ pin16;

  always_ff @(posedge pin14 or posedge pin15) begin
    if (pin15) js_q <= J4017_C0;
    else       js_q <= js_d;
  end

  always_comb begin
    js_d = js_q;
`ifdef STRUCT74_4017_SELFCORRECT_EN
    // Recovery bypasses the count enable so an illegal state never persists.
    if (!j4017_legal(js_q)) js_d = '0;
    else if (!pin13)        js_d = j4017_step(js_q);
`else
    if (!pin13) js_d = j4017_step(js_q);
`endif
  end

  johnson10_decode u_decode (
    .js_i    (js_q),
    .q_o     (q),
    .carry_o (carry)
  );

  assign pin3  = q[0];
  assign pin2  = q[1];
  assign pin4  = q[2];
  assign pin7  = q[3];
  assign pin10 = q[4];
  assign pin1  = q[5];
  assign pin5  = q[6];
  assign pin6  = q[7];
  assign pin9  = q[8];
  assign pin11 = q[9];
  assign pin12 = carry;

endmodule

// File: doc/decade_counter_4017.md
Name: decade_counter_4017

Overview:
- Pin-level model of the 74HC4017 Johnson decade counter with 1-of-10 decoded outputs, in the struct74 chip library alongside the other 74-series parts.
- Where the dual D flip-flop part stores single bits, this part is its counterpart on the sequencing side: a state machine that produces one-hot timing strobes.
- tinycpu uses it to sequence micro-steps: Q0..Q9 drive per-step enables, and pin12 gives a divide-by-10 carry.

Parameters:
- None. The pinout is fixed by the 16-pin DIP, and the counter width is fixed at 5 Johnson stages.

Ports:
- pin14  input   1  CP0 clock; counter advances on the rising edge
- pin15  input   1  MR master reset; asynchronous, active-high
- pin13  input   1  CP1 count enable; active-low, sampled synchronously on the pin14 rising edge
- pin8   input   1  GND; no functional effect
- pin16  input   1  VCC; no functional effect
- pin3   output  1  Q0, high when count = 0
- pin2   output  1  Q1
- pin4   output  1  Q2
- pin7   output  1  Q3
- pin10  output  1  Q4
- pin1   output  1  Q5
- pin5   output  1  Q6
- pin6   output  1  Q7
- pin9   output  1  Q8
- pin11  output  1  Q9
- pin12  output  1  Q5-9 carry; high for counts 0-4, low for counts 5-9

Behaviour:
- One clock (pin14). Reset is asynchronous and active-high (pin15). These are fixed.
- State is a 5-bit Johnson register js[4:0]. Legal sequence, count 0..9:
  00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000
- Johnson step rule: next = {js[3:0], ~js[4]}.
- Reset:
  - pin15 = 1 forces js = 00000 immediately, without waiting for a clock edge.
  - Reset dominates both pin14 and pin13.
  - Reset values of outputs: pin3 = 1, all other Q outputs = 0, pin12 = 1.
- Counting:
  - On a pin14 rising edge with pin15 = 0 and pin13 = 0, js takes one Johnson step.
  - With pin13 = 1, js holds.
- Wrap-around: count 9 (10000) steps to count 0 (00000). Ten enabled edges return the counter to its starting count.
- Decoded outputs:
  - Combinational from js; zero cycles of latency after a state change.
  - Each Qk is high only when js exactly equals the k-th legal encoding. An illegal js gives all Q outputs = 0.
  - Exactly one Q output is high in any legal state.
- Carry: pin12 = ~js[4], combinational.
- Reset released mid-sequence: the counter restarts at 0. The first enabled rising edge after pin15 falls moves it to count 1.
- Reset asserted and a clock edge arriving together: reset wins and js stays 00000.
- pin13 changing in the same timestep as the pin14 rise: the value sampled at the edge (pre-edge value) is the one used.
- X/Z on pin14 or pin13 while out of reset: js is not corrupted by a non-rising transition.

Optional Feature:
- Macro: STRUCT74_4017_SELFCORRECT_EN
- Defined: any illegal js steps to 00000 on the next pin14 rising edge. This happens regardless of pin13, so recovery takes at most 1 clock.
- Not defined: illegal states follow the plain Johnson step rule and can cycle indefinitely. Decoded outputs read all-zero whenever js is illegal.
- Legal-state behaviour is identical either way.

Decomposition:
- Shared struct74 package/header holds the ten legal Johnson encodings as named constants (J4017_C0..J4017_C9) and the 5-bit state width constant.
- One natural sub-module: johnson10_decode. It takes js[4:0] and produces the 10 one-hot outputs plus the carry. The top-level module owns the register, reset, enable and the optional correction logic.

Test Plan:
- Power-up reset: pin15 = 1 with no clock -> pin3 = 1, other Q = 0, pin12 = 1, immediately.
- Full count: pin13 = 0, 10 rising edges -> Q1..Q9 go high in order, then Q0. pin12 is low on edges 5-9 and high again on edge 10.
- Enable hold: count to 3, set pin13 = 1, apply 4 edges -> pin7 stays high. Set pin13 = 0, apply 1 edge -> pin10 high.
- Async reset mid-count: at count 7, pulse pin15 high between clock edges -> pin3 = 1 at once. First enabled edge after release -> pin2 = 1.
- Reset vs. clock: pin15 = 1 held through 5 rising edges with pin13 = 0 -> pin3 stays 1 throughout.
- Illegal state: force js = 01010 -> all Q = 0. With the macro defined, the next edge gives pin3 = 1. Without it, the next edge gives js = 10101 and all Q still 0.
